button_light_ctrl: RTL
======================

// Module: button_light_ctrl
// PURPOSE
//   Controller that sequences the on/off light from one raw push-button.
//   Synchronises and debounces the button, classifies each press as short or long,
//   and drives the light through OFF / ON / BLINK modes.
//   Sits between the board button pin and the light output; replaces direct button->light wiring.
// PARAMETERS
//   DEBOUNCE_CYC  16  consecutive stable cycles before the debounced level changes (>=2)
//   LONG_CYC      64  held cycles, counted from the debounced rise, that make a long press (>=2)
//   BLINK_HALF     8  cycles per blink half-period (>=1)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  reset, asynchronous assert, active-low
//   button     in   1  raw button, asynchronous and bouncy, 1 = pressed
//   light      out  1  registered light drive
//   pressed    out  1  debounced button level
//   short_evt  out  1  one-cycle pulse: short press completed
//   long_evt   out  1  one-cycle pulse: long-press threshold reached
//   mode       out  2  current mode: 0 OFF, 1 ON, 2 BLINK
// BEHAVIOUR
//   Reset (rst_n=0): light=0, pressed=0, short_evt=0, long_evt=0, mode=OFF.
//     All counters and synchroniser flops clear immediately, without waiting for clk.
//   Sync: 2-flop synchroniser on button; output s2.
//   Debounce:
//     - cnt clears whenever s2==pressed.
//     - cnt increments whenever s2!=pressed.
//     - pressed<=s2 on the edge where the mismatch has lasted DEBOUNCE_CYC consecutive cycles.
//     - Clean step on button -> pressed follows exactly DEBOUNCE_CYC+2 cycles later.
//     - Any mismatch shorter than DEBOUNCE_CYC is ignored.
//   Classifier:
//     - hold counter clears on the rising edge of pressed and counts while pressed=1.
//     - It saturates at LONG_CYC.
//     - long_evt pulses once, in the cycle hold reaches LONG_CYC, while the button is still held.
//     - short_evt pulses on the falling edge of pressed only if hold < LONG_CYC.
//     - A long press never yields short_evt; both pulses are never high in the same cycle.
//   Mode FSM (updates the cycle after an event pulse):
//     OFF   --short--> ON     OFF   --long--> BLINK
//     ON    --short--> OFF    ON    --long--> BLINK
//     BLINK --short--> OFF    BLINK --long--> ON
//   Light: OFF -> 0; ON -> 1.
//     BLINK -> 1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating.
//     Entry into BLINK restarts the blink counter with light=1 in the first cycle.
//   Button held across reset release: pressed is 0 after reset.
//     It rises DEBOUNCE_CYC+2 cycles later and is treated as a new press.
//   Widths: counters are $clog2(param+1) bits; no wrap-around is possible (saturating or cleared).
// STRUCTURE
//   Package light_ctrl_pkg:
//     - mode typedef/localparams MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2;
//     - default parameter constants.
//   Sub-module button_debounce: synchroniser plus debounce counter; output pressed.
//   Top holds the classifier, the mode FSM and the blink counter.
// TESTING (DEBOUNCE_CYC=4, LONG_CYC=20, BLINK_HALF=3, 10 ns clk)
//   1. Reset:
//      - rst_n=0, button=0 -> light=0, mode=0, pulses=0.
//      - rst_n=0 mid-BLINK, asynchronous to clk -> all outputs 0 before the next clk edge.
//   2. Bounce: button 1/0 every 2 cycles x3, then 0 -> pressed stays 0, no pulses, mode=0.
//   3. Short press: button=1 for 10 cycles from OFF.
//      - pressed rises 6 cycles after button.
//      - short_evt=1 for exactly 1 cycle, 6 cycles after release.
//      - mode=1, light=1.
//      - Repeating the same press -> mode=0, light=0.
//   4. Long press: button=1 for 40 cycles from OFF.
//      - long_evt exactly once, 20 cycles after pressed rises (button still held).
//      - No short_evt on release; mode=2.
//      - light pattern 1,1,1,0,0,0 repeating from entry.
//   5. From BLINK:
//      - Long press -> mode=1, light steady 1.
//      - Re-enter BLINK, then short press -> mode=0, light=0.
//   6. Reset mid-press: button held, pulse rst_n low.
//      - Outputs clear.
//      - After release of rst_n, pressed rises after 6 cycles; the later release gives short_evt and mode=1.

Source files
------------

// File: rtl/light_ctrl_pkg.sv
// Shared types and default tuning constants for the push-button light controller.
package light_ctrl_pkg;

  localparam int DEBOUNCE_CYC_DEF = 16;
  localparam int LONG_CYC_DEF     = 64;
  localparam int BLINK_HALF_DEF   = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser and run-length debouncer for the raw button pin.
// o_fall flags the cycle whose clock edge drops o_pressed, so press events can be registered on that same edge.
module button_debounce
  import light_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_pressed,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_pressed;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  assign w_flip = (r_s2 != r_pressed) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_pressed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1 <= i_button;
      r_s2 <= r_s1;
      if (r_s2 == r_pressed) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt     <= '0;
        r_pressed <= r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pressed = r_pressed;
  assign o_fall    = w_flip & r_pressed;

endmodule

// File: rtl/button_light_ctrl.sv
// Button-driven light controller: debounce, short/long press classification, mode FSM and blink timer.
//   state      | meaning
//   MODE_OFF   | light held at 0
//   MODE_ON    | light held at 1
//   MODE_BLINK | light toggles every BLINK_HALF cycles, starting high on entry
module button_light_ctrl
  import light_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int LONG_CYC     = LONG_CYC_DEF,
  parameter int BLINK_HALF   = BLINK_HALF_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_button,
  output logic       o_light,
  output logic       o_pressed,
  output logic       o_short_evt,
  output logic       o_long_evt,
  output logic [1:0] o_mode
);

  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LONG_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic          w_pressed;
  logic          w_fall;
  logic [HW-1:0] r_hold;
  logic          r_short_evt;
  logic          r_long_evt;
  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic          r_blink_on;
  logic          w_blink_on_nxt;
  logic          r_light;
  logic          w_light_nxt;

  button_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_button (i_button),
    .o_pressed(w_pressed),
    .o_fall   (w_fall)
  );

  // A release on the same edge that completes the hold counts as long, never short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_short_evt <= 1'b0;
      r_long_evt  <= 1'b0;
    end else begin
      if (!w_pressed) begin
        r_hold <= '0;
      end else if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + HW'(1);
      end
      r_long_evt  <= w_pressed && (r_hold == HOLD_LAST);
      r_short_evt <= w_fall && (r_hold < HOLD_LAST);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode      <= MODE_OFF;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
      r_light     <= 1'b0;
    end else begin
      r_mode      <= w_mode_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink_on  <= w_blink_on_nxt;
      r_light     <= w_light_nxt;
    end
  end

  always_comb begin
    w_mode_nxt      = r_mode;
    w_blink_cnt_nxt = '0;
    w_blink_on_nxt  = 1'b1;
    w_light_nxt     = 1'b0;

    case (r_mode)
      MODE_OFF: begin
        if (r_short_evt)     w_mode_nxt = MODE_ON;
        else if (r_long_evt) w_mode_nxt = MODE_BLINK;
      end
      MODE_ON: begin
        if (r_short_evt)     w_mode_nxt = MODE_OFF;
        else if (r_long_evt) w_mode_nxt = MODE_BLINK;
      end
      MODE_BLINK: begin
        if (r_short_evt)     w_mode_nxt = MODE_OFF;
        else if (r_long_evt) w_mode_nxt = MODE_ON;
      end
      default: w_mode_nxt = MODE_OFF;
    endcase

    if ((w_mode_nxt == MODE_BLINK) && (r_mode == MODE_BLINK)) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_nxt = '0;
        w_blink_on_nxt  = ~r_blink_on;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
        w_blink_on_nxt  = r_blink_on;
      end
    end

    w_light_nxt = (w_mode_nxt == MODE_ON) ||
                  ((w_mode_nxt == MODE_BLINK) && w_blink_on_nxt);
  end

  assign o_light     = r_light;
  assign o_pressed   = w_pressed;
  assign o_short_evt = r_short_evt;
  assign o_long_evt  = r_long_evt;
  assign o_mode      = r_mode;

endmodule
